// File: rtl/fsm1_pkg.sv
// fsm1_pkg -- shared types and encoding constants for the fsm1 read-strobe FSM.
//
// Contents:
//   ENC_IDLE/ENC_READ/ENC_DELAY/ENC_DONE : fixed 2-bit state encodings
//   state_t                              : enum used for the state register
package fsm1_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_READ  = 2'd1;
  localparam logic [1:0] ENC_DELAY = 2'd2;
  localparam logic [1:0] ENC_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    READ  = ENC_READ,
    DELAY = ENC_DELAY,
    DONE  = ENC_DONE
  } state_t;

endpackage

// File: rtl/fsm1_out_dec.sv
// fsm1_out_dec -- pure combinational decode from an fsm1 state to its strobes.
//
// Ports:
//   state : input  state_t  state to decode (current or next, depending on build)
//   rd    : output logic    read strobe, high in READ and DELAY
//   ds    : output logic    done strobe, high in DONE
module fsm1_out_dec
  import fsm1_pkg::*;
(
  input  state_t state,
  output logic   rd,
  output logic   ds
);

  // Unknown or illegal encodings fall through to the all-zero defaults.
  always_comb begin
    rd = 1'b0;
    ds = 1'b0;
    case (state)
      READ:    rd = 1'b1;
      DELAY:   rd = 1'b1;
      DONE:    ds = 1'b1;
      default: begin
        rd = 1'b0;
        ds = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fsm1.sv
// fsm1 -- four-state Moore FSM sequencing a read transaction with wait states.
//
// Ports:
//   clock   : input  rising-edge clock
//   reset_n : input  asynchronous active-low reset (forces IDLE, outputs 0)
//   go      : input  start request, only looked at in IDLE
//   ws      : input  wait-state request, only looked at in DELAY
//   rd      : output read strobe (READ, DELAY)
//   ds      : output done strobe (DONE)
//
// Build option:
//   FSM1_REG_OUT_EN : when defined, rd/ds are flops fed from the decode of the
//                     next state, so they switch on the same edge as state but
//                     come straight off a register. Undefined: rd/ds are a
//                     combinational decode of state. Both are cycle-identical.
module fsm1
  import fsm1_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic go,
  input  logic ws,
  output logic rd,
  output logic ds
);

  state_t state;
  state_t next_state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Anything not explicitly handled, including X/illegal state values,
  // recovers to IDLE on the next edge.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = go ? READ : IDLE;
      READ:    next_state = DELAY;
      DELAY:   next_state = ws ? READ : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef FSM1_REG_OUT_EN
  logic next_rd;
  logic next_ds;

  fsm1_out_dec u_out_dec (
    .state (next_state),
    .rd    (next_rd),
    .ds    (next_ds)
  );

  // Loading from the next-state decode keeps the strobes aligned with state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd <= 1'b0;
      ds <= 1'b0;
    end else begin
      rd <= next_rd;
      ds <= next_ds;
    end
  end
`else
  fsm1_out_dec u_out_dec (
    .state (state),
    .rd    (rd),
    .ds    (ds)
  );
`endif

endmodule

// File: tb/tb_fsm1.sv
// tb_fsm1 -- self-checking bench for fsm1 (works for either FSM1_REG_OUT_EN build).
//
// A transaction-level model tracks whether a read is active, how many cycles
// into it we are (odd = read cycle, even = delay cycle) and whether it is
// finishing. A compare process checks the DUT against that model every falling
// edge; directed steps additionally check hand-computed literal values.
module tb_fsm1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic go      = 1'b0;
  logic ws      = 1'b0;
  logic rd;
  logic ds;

  int pass_count  = 0;
  int check_count = 0;
  bit check_en    = 1'b0;

  fsm1 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .go      (go),
    .ws      (ws),
    .rd      (rd),
    .ds      (ds)
  );

  always #5 clock = ~clock;

  // Transaction model: active = a read is in progress, cyc = cycle index within
  // it (1,3,5.. are read cycles, 2,4,6.. are delay cycles), fin = completion cycle.
  bit m_active = 1'b0;
  int m_cyc    = 0;
  bit m_fin    = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_cyc    <= 0;
      m_fin    <= 1'b0;
    end else if (m_fin) begin
      m_active <= 1'b0;
      m_fin    <= 1'b0;
    end else if (m_active) begin
      if ((m_cyc % 2) == 1 || ws) m_cyc <= m_cyc + 1;
      else                        m_fin <= 1'b1;
    end else if (go) begin
      m_active <= 1'b1;
      m_cyc    <= 1;
    end
  end

  function automatic string model_name();
    if (!m_active)          return "IDLE";
    if (m_fin)              return "DONE";
    if ((m_cyc % 2) == 1)   return "READ";
    return "DELAY";
  endfunction

  // One comparison of state name and both strobes against expected values.
  task automatic checkOutput(input string label, input string exp_name,
                             input logic exp_rd, input logic exp_ds);
    string act_name;
    act_name = dut.state.name();
    check_count++;
    if (act_name == exp_name && rd === exp_rd && ds === exp_ds) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s @%0t: got state=%s rd=%b ds=%b, expected state=%s rd=%b ds=%b",
               label, $time, act_name, rd, ds, exp_name, exp_rd, exp_ds);
    end
  endtask

  // Drive inputs just after a rising edge, then step past the next edge.
  task automatic applyStimulus(input logic g, input logic w);
    go = g;
    ws = w;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("model", model_name(), m_active && !m_fin, m_fin);
    end
  end

  logic [31:0] go_pat;
  logic [31:0] ws_pat;

  initial begin
    // Reset held for one edge, then released with idle inputs.
    @(posedge clock);
    #1;
    check_en = 1'b1;
    checkOutput("reset", "IDLE", 1'b0, 1'b0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset_1", "IDLE", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset_2", "IDLE", 1'b0, 1'b0);

    // Basic read: go held two cycles, go ignored in READ.
    applyStimulus(1'b1, 1'b0);
    checkOutput("basic_read", "READ", 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("basic_delay", "DELAY", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("basic_done", "DONE", 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("basic_idle", "IDLE", 1'b0, 1'b0);

    // Wait loop: two wait states, ws ignored while in READ.
    applyStimulus(1'b1, 1'b0);
    checkOutput("wait_read0", "READ", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("wait_delay0", "DELAY", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wait_read1", "READ", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wait_delay1", "DELAY", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wait_read2", "READ", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("wait_delay2", "DELAY", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("wait_done", "DONE", 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("wait_idle", "IDLE", 1'b0, 1'b0);

    // Ignored inputs: ws in IDLE, go in DELAY and DONE.
    applyStimulus(1'b0, 1'b1);
    checkOutput("ws_in_idle", "IDLE", 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ign_read", "READ", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ign_delay", "DELAY", 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("go_in_delay", "DONE", 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("go_in_done", "IDLE", 1'b0, 1'b0);

    // Async abort from DELAY, well before the next rising edge.
    applyStimulus(1'b1, 1'b0);
    checkOutput("abort_read", "READ", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_delay", "DELAY", 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_async", "IDLE", 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("abort_held", "IDLE", 1'b0, 1'b0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("release_idle", "IDLE", 1'b0, 1'b0);

    // Abort from DONE: no ds may survive the reset.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort2_done", "DONE", 1'b0, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("abort2_async", "IDLE", 1'b0, 1'b0);
    #2;
    reset_n = 1'b1;

    // Fixed input patterns; the compare process checks every cycle.
    go_pat = 32'hB4E1_9C37;
    ws_pat = 32'h6D2A_F158;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(go_pat[i], ws_pat[i]);
    end
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("final_idle", "IDLE", 1'b0, 1'b0);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fsm1.md
FSM1 -- requirements
Module: fsm1

Interface
- REQ-001: The module SHALL have no parameters; the state encoding is fixed by the package.
- REQ-002: clock  input  1  single clock; all state updates on its rising edge.
- REQ-003: reset_n  input  1  asynchronous, active-low reset.
- REQ-004: go  input  1  request to start a read transaction; sampled in IDLE only.
- REQ-005: ws  input  1  wait-state request; sampled in DELAY only.
- REQ-006: rd  output  1  read strobe; high in READ and DELAY.
- REQ-007: ds  output  1  done strobe; high in DONE only.
- REQ-008: The internal state register SHALL be named state, of enum type state_t, so benches can probe state and state.name hierarchically.

Function
- REQ-009: Moore FSM with four states, 2-bit encoding: IDLE=2'd0, READ=2'd1, DELAY=2'd2, DONE=2'd3.
- REQ-010: IDLE: go=1 -> READ; go=0 -> stay in IDLE; ws is ignored.
- REQ-011: READ: unconditionally -> DELAY after one cycle; go and ws are ignored.
- REQ-012: DELAY: ws=1 -> READ (wait-state loop); ws=0 -> DONE; go is ignored.
- REQ-013: DONE: unconditionally -> IDLE after one cycle; go=1 in DONE does not skip IDLE.
- REQ-014: Output decode: IDLE {ds,rd}=00, READ 01, DELAY 01, DONE 10; {ds,rd}=11 is never produced.
- REQ-015: Latency: an input change before a rising edge becomes visible in state and outputs right after that edge (one-cycle transition latency).
- REQ-016: The minimum transaction, go pulse to return to IDLE, SHALL take 4 cycles: READ, DELAY, DONE, IDLE.
- REQ-017: Each additional cycle of ws=1 in DELAY adds a READ+DELAY pair (2 cycles); unbounded waits are allowed.
- REQ-018: X-handling: any illegal or unknown state value SHALL go to IDLE on the next edge, with default outputs 0.

Reset
- REQ-019: While reset_n=0, state SHALL be IDLE and rd=0, ds=0, asynchronously and regardless of clock.
- REQ-020: Reset asserted mid-transaction (READ/DELAY/DONE) SHALL abort immediately to IDLE with outputs 0; no ds is issued.
- REQ-021: After reset_n rises, the first rising edge SHALL evaluate the IDLE transition normally; with go=0 the FSM stays in IDLE.

Configuration
- REQ-022: Macro FSM1_REG_OUT_EN: when defined, rd and ds SHALL be flops loaded from the next-state decode, giving cycle timing identical to REQ-014 and glitch-free outputs, reset to 0.
- REQ-023: Without FSM1_REG_OUT_EN, rd and ds SHALL be combinational decodes of state.
- REQ-024: In both builds the external behaviour SHALL be cycle-identical.

Structure
- REQ-025: Package fsm1_pkg SHALL hold typedef enum logic [1:0] state_t {IDLE, READ, DELAY, DONE} and the encoding constants.
- REQ-026: One sub-module, fsm1_out_dec, SHALL be the pure combinational state-to-{ds,rd} decode, used by both configuration variants.
- REQ-027: Next-state logic SHALL be a single combinational block with a default assignment of IDLE.

Verification
- REQ-028: Reset: reset_n=0 for 1 cycle, then 1, go=0, ws=0 for 2 cycles -> state=IDLE, rd=0, ds=0 throughout.
- REQ-029: Basic read: go=1 for 2 cycles -> READ (rd=1), then DELAY (rd=1); ws=0 -> DONE (ds=1, rd=0), then IDLE (00).
- REQ-030: Wait loop: in DELAY set go=0, ws=1 -> READ then DELAY (rd=1 both); ws=0 -> DONE, then IDLE.
- REQ-031: Ignored inputs: ws=1 in IDLE keeps IDLE; go toggled during READ/DELAY/DONE does not change the sequence.
- REQ-032: Async abort: reset_n=0 mid-cycle while in DELAY -> state=IDLE and rd=0 before the next clock edge.
- REQ-033: Rebuild with FSM1_REG_OUT_EN and rerun REQ-028..032 -> identical state/rd/ds traces.
